// File: rtl/run_counter_pkg.sv
// Shared constants and state encoding for the run_counter family.
package run_counter_pkg;

  // Terminal-count behaviour selected by the MODE parameter.
  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/run_counter_step.sv
// Combinational stepping logic: next count one step toward the terminal,
// the origin to return to, and whether the count already sits at the terminal.
module run_counter_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit_q,
  input  logic             dir_q,
  output logic [WIDTH-1:0] next_count,
  output logic [WIDTH-1:0] origin,
  output logic             is_terminal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Up counts toward limit_q from 0; down counts toward 0 from limit_q.
  always_comb begin
    next_count  = dir_q ? (count + ONE) : (count - ONE);
    origin      = dir_q ? '0 : limit_q;
    is_terminal = dir_q ? (count == limit_q) : (count == '0);
  end

endmodule

// File: rtl/run_counter.sv
// Start/stop event counter with programmable terminal value, direction,
// pause/resume, synchronous clear and a one-cycle terminal-count pulse.
module run_counter
  import run_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             tc
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q,   dir_d;
  logic             tc_q,    tc_d;

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] origin;
  logic             is_terminal;

  run_counter_step #(.WIDTH(WIDTH)) u_step (
    .count       (count_q),
    .limit_q     (limit_q),
    .dir_q       (dir_q),
    .next_count  (next_count),
    .origin      (origin),
    .is_terminal (is_terminal)
  );

  // Next-state and next-register logic; priority clear > stop > start > count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // Fresh start: sample limit and direction, load the origin.
          if (start && !stop) begin
            state_d = RUN;
            limit_d = limit;
            dir_d   = up_dn;
            count_d = up_dn ? '0 : limit;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (is_terminal) begin
            tc_d = 1'b1;
            if (MODE == MODE_SAT) begin
              state_d = DONE;
            end else if (MODE == MODE_ONESHOT) begin
              count_d = origin;
              state_d = DONE;
            end else begin
              count_d = origin;
            end
          end else begin
            count_d = next_count;
          end
        end
        PAUSE: begin
          // Resume keeps count, limit_q and dir_q untouched.
          if (start && !stop) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  // Status flags are decoded directly from the state register.
  always_comb begin
    count   = count_q;
    tc      = tc_q;
    running = (state_q == RUN);
    paused  = (state_q == PAUSE);
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_run_counter.sv
// Directed bench for run_counter: one instance per terminal mode, all driven
// by the same stimulus; each step checks the instance of interest.
module tb_run_counter;
  import run_counter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, clear, up_dn;
  logic [W-1:0] limit;

  logic [W-1:0] count_w, count_s, count_o;
  logic         run_w, run_s, run_o;
  logic         pau_w, pau_s, pau_o;
  logic         done_w, done_s, done_o;
  logic         tc_w, tc_s, tc_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  run_counter #(.WIDTH(W), .MODE(MODE_WRAP)) dut_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .limit(limit), .count(count_w), .running(run_w),
    .paused(pau_w), .done(done_w), .tc(tc_w)
  );

  run_counter #(.WIDTH(W), .MODE(MODE_SAT)) dut_s (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .limit(limit), .count(count_s), .running(run_s),
    .paused(pau_s), .done(done_s), .tc(tc_s)
  );

  run_counter #(.WIDTH(W), .MODE(MODE_ONESHOT)) dut_o (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .limit(limit), .count(count_o), .running(run_o),
    .paused(pau_o), .done(done_o), .tc(tc_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    up_dn = 1'b1; limit = '0;
    repeat (2) tick();
    check("rst_count", {4'b0, count_w}, 8'd0);
    check("rst_flags", {4'b0, run_w, pau_w, done_w, tc_w}, 8'd0);
    reset = 1'b0;
    tick();
    check("idle_hold", {4'b0, count_w}, 8'd0);

    // WRAP up, limit 15.
    limit = 4'd15; up_dn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("w15_start_cnt", {4'b0, count_w}, 8'd0);
    check("w15_start_run", {7'b0, run_w}, 8'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("w15_cnt", {4'b0, count_w}, 8'(i));
      check("w15_tc_low", {7'b0, tc_w}, 8'd0);
    end
    tick();
    check("w15_wrap_cnt", {4'b0, count_w}, 8'd0);
    check("w15_wrap_tc", {7'b0, tc_w}, 8'd1);
    check("w15_wrap_run", {7'b0, run_w}, 8'd1);
    tick();
    check("w15_after_cnt", {4'b0, count_w}, 8'd1);
    check("w15_after_tc", {7'b0, tc_w}, 8'd0);
    do_clear();
    check("clr_idle_w", {4'b0, count_w, run_w}, 8'd0);

    // WRAP up, limit 9, pause at 5 for 3 cycles, resume.
    limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("p_at5", {4'b0, count_w}, 8'd5);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p_hold_cnt", {4'b0, count_w}, 8'd5);
      check("p_hold_flag", {6'b0, pau_w, run_w}, 8'b10);
    end
    stop = 1'b0; limit = 4'd2; up_dn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; limit = 4'd9; up_dn = 1'b1;
    check("p_resume_cnt", {4'b0, count_w}, 8'd5);
    check("p_resume_flag", {6'b0, pau_w, run_w}, 8'b01);
    tick();
    check("p_step6", {4'b0, count_w}, 8'd6);
    tick();
    check("p_step7", {4'b0, count_w}, 8'd7);
    do_clear();

    // SATURATE down, limit 9.
    limit = 4'd9; up_dn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("s_start_cnt", {4'b0, count_s}, 8'd9);
    for (int i = 8; i >= 0; i--) begin
      tick();
      check("s_cnt", {4'b0, count_s}, 8'(i));
      check("s_tc_low", {7'b0, tc_s}, 8'd0);
    end
    tick();
    check("s_term_cnt", {4'b0, count_s}, 8'd0);
    check("s_term_flags", {5'b0, run_s, done_s, tc_s}, 8'b011);
    tick();
    check("s_held_cnt", {4'b0, count_s}, 8'd0);
    check("s_held_flags", {5'b0, run_s, done_s, tc_s}, 8'b010);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s_restart_cnt", {4'b0, count_s}, 8'd9);
    check("s_restart_flags", {6'b0, run_s, done_s}, 8'b10);
    tick();
    check("s_restart_step", {4'b0, count_s}, 8'd8);
    do_clear();

    // ONESHOT up, limit 3.
    limit = 4'd3; up_dn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("o_start", {4'b0, count_o}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("o_cnt", {4'b0, count_o}, 8'(i));
    end
    tick();
    check("o_term_cnt", {4'b0, count_o}, 8'd0);
    check("o_term_flags", {5'b0, run_o, done_o, tc_o}, 8'b011);
    repeat (2) begin
      tick();
      check("o_hold", {3'b0, count_o, done_o}, 8'b00001);
      check("o_hold_tc", {7'b0, tc_o}, 8'd0);
    end
    do_clear();
    check("o_clear", {3'b0, count_o, done_o}, 8'd0);

    // start+stop together in RUN at 4, then clear+start in PAUSE.
    limit = 4'd9; up_dn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    check("ss_pause_cnt", {4'b0, count_w}, 8'd4);
    check("ss_pause_flag", {6'b0, pau_w, run_w}, 8'b10);
    tick();
    check("ss_stay_pause", {3'b0, count_w, pau_w}, 8'b01001);
    stop = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("cs_idle_cnt", {4'b0, count_w}, 8'd0);
    check("cs_idle_flags", {6'b0, pau_w, run_w}, 8'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_idle_norun", {7'b0, run_w}, 8'd0);

    // Asynchronous reset mid-count at 7.
    limit = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("ar_at7", {4'b0, count_w}, 8'd7);
    #2 reset = 1'b1;
    #1;
    check("ar_cnt", {4'b0, count_w}, 8'd0);
    check("ar_flags_w", {4'b0, run_w, pau_w, done_w, tc_w}, 8'd0);
    tick();
    reset = 1'b0;

    // limit 0 WRAP: tc every cycle, count stays 0.
    limit = 4'd0; up_dn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("z_start", {3'b0, count_w, tc_w}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("z_tc", {3'b0, count_w, tc_w}, 8'b00001);
      check("z_run", {7'b0, run_w}, 8'd1);
    end
    check("z_sat_done", {4'b0, count_s, done_s}, 8'b00001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
